issue_dispatch_ctrl: RTL and testbench
======================================

# issue_dispatch_ctrl

Dual-issue scheduler between decode and the Issue→EXE pipeline register. It buffers decoded instructions in a circular issue queue, accepting up to two per cycle. Each cycle it picks 0, 1 or 2 in-order instructions from the head for issue, using three checks: intra-pair RAW, structural class conflicts and load-use hazards. It honours the pipeline stall and branch-flush signals.

## Interface
- DEPTH, 8: queue entries; power of two, ≥4.
- DATA_W, 256: opaque payload width (decoded control word, carried unchanged).
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  2  enqueue request; bit0 is the older instruction. 2'b10 is illegal.
- in_ready  out  1  queue has ≥2 free entries.
- in_data  in  2×DATA_W  payloads.
- in_rd, in_rj, in_rk  in  2×5  destination and source register numbers.
- in_we  in  2  register write enable.
- in_cls  in  2×3  class bits, one per instruction: {solo, muldiv, mem}.
- ex_ld_valid  in  2  EX slots A/B hold a load.
- ex_ld_rd  in  2×5  EX load destinations.
- stall  in  1  stall_DCache | stall_div.
- flush  in  1  branch flush.
- out_valid  out  2  issue slot0 (older) / slot1 (younger).
- out_data  out  2×DATA_W  issued payloads.
- out_rj, out_rk  out  2×5  register-file read addresses.
- count  out  log2(DEPTH)+1  current occupancy.

## Operation
- Storage:
  - head pointer, tail pointer, count register.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Enqueue:
  - Condition: in_ready && !flush.
  - Writes popcount(in_valid) entries at tail and tail+1.
  - Tail advances by the same amount.
  - When in_ready=0, in_valid is ignored and nothing is written.
- Candidates: c0 = entry[head] if count≥1; c1 = entry[head+1] if count≥2.
- Load-use for instruction x:
  - Hazard when ex_ld_valid[i] && ex_ld_rd[i]!=0 && ex_ld_rd[i]∈{x.rj, x.rk}, for either EX slot i.
- issue0 = count≥1 && !stall && !flush && !loaduse(c0).
- issue1 requires all of the following:
  - issue0 && count≥2 && !loaduse(c1).
  - No RAW: not (c0.we && c0.rd!=0 && c0.rd∈{c1.rj, c1.rk}).
  - Neither instruction has cls.solo.
  - Not both cls.mem.
  - Not both cls.muldiv.
- Outputs:
  - out_valid = {issue1, issue0}.
  - out_data, out_rj and out_rk are driven from c0/c1 even when not valid.
- Dequeue: head += issue0+issue1.
- count_next = count + enq − deq. Simultaneous enqueue and dequeue is legal, including on a full or empty queue.
- Flush:
  - head, tail and count go to 0.
  - Any same-cycle enqueue is dropped.
  - out_valid = 0 in that cycle.
  - Flush has priority over stall.
- Stall:
  - No dequeue; out_valid = 0.
  - Enqueue proceeds normally.
- Never issues c1 without c0; in-order issue only.

## Timing
- Reset values: head=tail=count=0, out_valid=2'b00, in_ready=1. Storage contents are don't-care.
- Issue decision is combinational from queue state and the EX/stall/flush inputs.
- The downstream register samples the outputs at the next edge.
- Enqueue→issue latency is 1 cycle: data written at edge t is eligible at head during cycle t+1.
- in_ready is derived from the registered count only, with no combinational path from out_valid. The queue therefore refuses when free<2, even if a dequeue is occurring.
- count==DEPTH: in_ready=0. count==0: out_valid=0.
- rstn low mid-operation: all state is cleared at that edge; outputs take their reset values in the following cycle.

## Structure
- Public_Info package gets:
  - class-bit constants CLS_MEM=0, CLS_MULDIV=1, CLS_SOLO=2.
  - the iq_meta_t struct {rd, rj, rk, we, cls}.
- The decoder maps inst_type into the class bits: CSR, ertn, syscall and other privileged instructions → solo.
- Sub-module iq_pair_hazard: combinational. Inputs: c0/c1 meta and the EX load info. Outputs: loaduse0, loaduse1, pair_ok.
- Queue storage and pointers live in the top module.

## Test plan
- Reset, then enqueue two independent ALU instructions (r1←, r2←) with in_valid=2'b11 → next cycle out_valid=2'b11; count returns 2→0.
- Pair c0: rd=5 we=1; c1: rj=5 → out_valid=2'b01. Following cycle c1 issues alone in slot0 with out_valid=2'b01.
- ex_ld_valid=2'b01, ex_ld_rd[0]=7, c0.rk=7 → out_valid=2'b00. Drop ex_ld_valid → c0 issues.
- Two mem instructions → single issue each. A solo (CSR) instruction at c1 after an ALU at c0 → ALU alone, then CSR alone, then the next instruction issues.
- Fill to DEPTH=8 while stall=1 → in_ready=0 at count≥7; count holds at 8 with no overflow. Release stall → drains 2 per cycle with pointers wrapping.
- count=4, flush=1 with in_valid=2'b11 → next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/issue_dispatch_ctrl_pkg.sv
// Shared types for the dual-issue queue: instruction class bits, per-entry
// hazard metadata and the load-use match helper.
package issue_dispatch_ctrl_pkg;

    localparam int CLS_MEM    = 0;
    localparam int CLS_MULDIV = 1;
    localparam int CLS_SOLO   = 2;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rj;
        logic [4:0] rk;
        logic       we;
        logic [2:0] cls;
    } iq_meta_t;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use(input iq_meta_t m, input logic [1:0] ld_v,
                                      input logic [9:0] ld_rd);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (ld_v[i] && (ld_rd[i*5 +: 5] != 5'd0) &&
                ((ld_rd[i*5 +: 5] == m.rj) || (ld_rd[i*5 +: 5] == m.rk))) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/issue_dispatch_ctrl_hazard.sv
// Pair-issue legality: load-use on each candidate plus RAW and class-conflict
// checks that decide whether the younger candidate may issue beside the older.
module iq_pair_hazard
    import issue_dispatch_ctrl_pkg::*;
(
    input  iq_meta_t   c0,
    input  iq_meta_t   c1,
    input  logic [1:0] ex_ld_valid,
    input  logic [9:0] ex_ld_rd,
    output logic       loaduse0,
    output logic       loaduse1,
    output logic       pair_ok
);

    logic raw_s;
    logic solo_s;
    logic mem_s;
    logic muldiv_s;
    logic unused_s;

    // c1's own destination never affects pairing.
    assign unused_s = ^{c1.rd, c1.we};

    // Hazard evaluation for the two head candidates.
    always_comb begin
        loaduse0 = load_use(c0, ex_ld_valid, ex_ld_rd);
        loaduse1 = load_use(c1, ex_ld_valid, ex_ld_rd);
        raw_s    = c0.we && (c0.rd != 5'd0) && ((c0.rd == c1.rj) || (c0.rd == c1.rk));
        solo_s   = c0.cls[CLS_SOLO] || c1.cls[CLS_SOLO];
        mem_s    = c0.cls[CLS_MEM] && c1.cls[CLS_MEM];
        muldiv_s = c0.cls[CLS_MULDIV] && c1.cls[CLS_MULDIV];
        pair_ok  = !(raw_s || solo_s || mem_s || muldiv_s);
    end

endmodule

// File: rtl/issue_dispatch_ctrl.sv
// Dual-issue scheduler: circular issue queue fed by decode, issuing 0-2
// in-order instructions per cycle toward the Issue->EXE pipeline register.
module issue_dispatch_ctrl
    import issue_dispatch_ctrl_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 256
)
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_W-1:0]     in_data,
    input  logic [9:0]              in_rd,
    input  logic [9:0]              in_rj,
    input  logic [9:0]              in_rk,
    input  logic [1:0]              in_we,
    input  logic [5:0]              in_cls,
    input  logic [1:0]              ex_ld_valid,
    input  logic [9:0]              ex_ld_rd,
    input  logic                    stall,
    input  logic                    flush,
    output logic [1:0]              out_valid,
    output logic [2*DATA_W-1:0]     out_data,
    output logic [9:0]              out_rj,
    output logic [9:0]              out_rk,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_TWO     = CW'(2);
    localparam logic [CW-1:0] CNT_RDY_MAX = CW'(DEPTH - 2);

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]     c1_idx_s, wr1_idx_s;
    logic [CW-1:0]     count_q, count_d, enq_n_s, deq_n_s;
    logic              enq_ok_s, issue0_s, issue1_s;
    logic              loaduse0_s, loaduse1_s, pair_ok_s;
    logic [DATA_W-1:0] data_q [DEPTH];
    iq_meta_t          meta_q [DEPTH];
    iq_meta_t          in_meta_s [2];

    // Only the registered count gates acceptance, so a same-cycle dequeue never frees room.
    assign in_ready = (count_q <= CNT_RDY_MAX);
    assign c1_idx_s = head_q + PW'(1);

    // Unpack the decode-side metadata lanes.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_meta_s[i].rd  = in_rd[i*5 +: 5];
            in_meta_s[i].rj  = in_rj[i*5 +: 5];
            in_meta_s[i].rk  = in_rk[i*5 +: 5];
            in_meta_s[i].we  = in_we[i];
            in_meta_s[i].cls = in_cls[i*3 +: 3];
        end
    end

    iq_pair_hazard u_hazard (
        .c0          (meta_q[head_q]),
        .c1          (meta_q[c1_idx_s]),
        .ex_ld_valid (ex_ld_valid),
        .ex_ld_rd    (ex_ld_rd),
        .loaduse0    (loaduse0_s),
        .loaduse1    (loaduse1_s),
        .pair_ok     (pair_ok_s)
    );

    // Issue selection, enqueue sizing and next pointer/count state.
    always_comb begin
        enq_ok_s = in_ready && !flush;
        if (enq_ok_s) begin
            enq_n_s = CW'(in_valid[0]) + CW'(in_valid[1]);
        end else begin
            enq_n_s = '0;
        end
        if (in_valid[0]) begin
            wr1_idx_s = tail_q + PW'(1);
        end else begin
            wr1_idx_s = tail_q;
        end
        issue0_s = (count_q >= CNT_ONE) && !stall && !flush && !loaduse0_s;
        issue1_s = issue0_s && (count_q >= CNT_TWO) && !loaduse1_s && pair_ok_s;
        deq_n_s  = CW'(issue0_s) + CW'(issue1_s);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + deq_n_s[PW-1:0];
            tail_d  = tail_q + enq_n_s[PW-1:0];
            count_d = count_q + enq_n_s - deq_n_s;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (enq_ok_s && in_valid[0]) begin
            data_q[tail_q] <= in_data[DATA_W-1:0];
            meta_q[tail_q] <= in_meta_s[0];
        end
        if (enq_ok_s && in_valid[1]) begin
            data_q[wr1_idx_s] <= in_data[2*DATA_W-1:DATA_W];
            meta_q[wr1_idx_s] <= in_meta_s[1];
        end
    end

    assign out_valid = {issue1_s, issue0_s};
    assign out_data  = {data_q[c1_idx_s], data_q[head_q]};
    assign out_rj    = {meta_q[c1_idx_s].rj, meta_q[head_q].rj};
    assign out_rk    = {meta_q[c1_idx_s].rk, meta_q[head_q].rk};
    assign count     = count_q;

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Directed, table-driven bench for issue_dispatch_ctrl: one table row per clock
// cycle with hand-computed out_valid / in_ready / count and issued tags.
module tb_issue_dispatch_ctrl;
    import issue_dispatch_ctrl_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 256;
    localparam logic [2:0] ALU  = 3'b000;
    localparam logic [2:0] MEM  = 3'b001;
    localparam logic [2:0] MD   = 3'b010;
    localparam logic [2:0] SOLO = 3'b100;

    typedef struct packed {
        logic [7:0] tag;
        logic [4:0] rd;
        logic [4:0] rj;
        logic [4:0] rk;
        logic       we;
        logic [2:0] cls;
    } ins_t;

    typedef struct {
        logic       rstn, stall, flush;
        logic [1:0] iv;
        ins_t       i0, i1;
        logic [1:0] exv;
        logic [4:0] exrd0, exrd1;
        logic [1:0] ev;
        logic       er;
        logic [3:0] ec;
        logic [7:0] et0, et1;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [1:0]            in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   in_data;
    logic [9:0]            in_rd, in_rj, in_rk;
    logic [1:0]            in_we;
    logic [5:0]            in_cls;
    logic [1:0]            ex_ld_valid;
    logic [9:0]            ex_ld_rd;
    logic                  stall, flush;
    logic [1:0]            out_valid;
    logic [2*DATA_W-1:0]   out_data;
    logic [9:0]            out_rj, out_rk;
    logic [3:0]            count;

    vec_t vecs[$];
    ins_t by_tag [256];
    ins_t nn;
    int   checks = 0;
    int   passed = 0;

    issue_dispatch_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk),
        .in_we(in_we), .in_cls(in_cls), .ex_ld_valid(ex_ld_valid),
        .ex_ld_rd(ex_ld_rd), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_rj(out_rj),
        .out_rk(out_rk), .count(count)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk(input int tag, input int rd, input int rj, input int rk,
                                input logic we, input logic [2:0] cls);
        ins_t x;
        x.tag = 8'(tag);
        x.rd  = 5'(rd);
        x.rj  = 5'(rj);
        x.rk  = 5'(rk);
        x.we  = we;
        x.cls = cls;
        return x;
    endfunction

    task automatic add(input logic r, input logic st, input logic fl, input logic [1:0] iv,
                       input ins_t a, input ins_t b, input logic [1:0] exv, input int e0,
                       input int e1, input logic [1:0] ev, input logic er, input int ec,
                       input int t0, input int t1);
        vec_t v;
        v.rstn = r; v.stall = st; v.flush = fl; v.iv = iv; v.i0 = a; v.i1 = b;
        v.exv = exv; v.exrd0 = 5'(e0); v.exrd1 = 5'(e1);
        v.ev = ev; v.er = er; v.ec = 4'(ec); v.et0 = 8'(t0); v.et1 = 8'(t1);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check outputs 1 time unit later.
    task automatic apply(input vec_t v, input int idx);
        logic [7:0] t;
        @(negedge clk);
        rstn        = v.rstn;
        stall       = v.stall;
        flush       = v.flush;
        in_valid    = v.iv;
        in_data     = {{32{v.i1.tag}}, {32{v.i0.tag}}};
        in_rd       = {v.i1.rd, v.i0.rd};
        in_rj       = {v.i1.rj, v.i0.rj};
        in_rk       = {v.i1.rk, v.i0.rk};
        in_we       = {v.i1.we, v.i0.we};
        in_cls      = {v.i1.cls, v.i0.cls};
        ex_ld_valid = v.exv;
        ex_ld_rd    = {v.exrd1, v.exrd0};
        if (v.iv[0]) by_tag[v.i0.tag] = v.i0;
        if (v.iv[1]) by_tag[v.i1.tag] = v.i1;
        #1;
        chk($sformatf("row%0d out_valid", idx), 512'(out_valid), 512'(v.ev));
        chk($sformatf("row%0d in_ready", idx), 512'(in_ready), 512'(v.er));
        chk($sformatf("row%0d count", idx), 512'(count), 512'(v.ec));
        if (v.ev[0]) begin
            t = v.et0;
            chk($sformatf("row%0d data0", idx), 512'(out_data[DATA_W-1:0]), 512'({32{t}}));
            chk($sformatf("row%0d rj0", idx), 512'(out_rj[4:0]), 512'(by_tag[t].rj));
            chk($sformatf("row%0d rk0", idx), 512'(out_rk[4:0]), 512'(by_tag[t].rk));
        end
        if (v.ev[1]) begin
            t = v.et1;
            chk($sformatf("row%0d data1", idx), 512'(out_data[2*DATA_W-1:DATA_W]), 512'({32{t}}));
            chk($sformatf("row%0d rj1", idx), 512'(out_rj[9:5]), 512'(by_tag[t].rj));
        end
    endtask

    initial begin
        vec_t v;
        nn = '0;
        rstn = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 2'b00; in_data = '0;
        in_rd = '0; in_rj = '0; in_rk = '0; in_we = '0; in_cls = '0;
        ex_ld_valid = 2'b00; ex_ld_rd = '0;
        repeat (2) @(posedge clk);

        // independent ALU pair dual-issues
        add(1,0,0,2'b11, mk(1,1,0,0,1,ALU), mk(2,2,0,0,1,ALU), 0,0,0, 2'b00,1,0,0,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b11,1,2,1,2);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b00,1,0,0,0);
        // RAW splits the pair
        add(1,0,0,2'b11, mk(3,5,1,2,1,ALU), mk(4,6,5,0,1,ALU), 0,0,0, 2'b00,1,0,0,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b01,1,2,3,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b01,1,1,4,0);
        // rd=0 and we=0 producers create no RAW
        add(1,0,0,2'b11, mk(5,0,0,0,1,ALU), mk(6,7,0,0,1,ALU), 0,0,0, 2'b00,1,0,0,0);
        add(1,0,0,2'b11, mk(7,5,0,0,0,ALU), mk(8,9,5,5,1,ALU), 0,0,0, 2'b11,1,2,5,6);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b11,1,2,7,8);
        // load-use on c0 from EX slot A, then slot B, then released
        add(1,0,0,2'b01, mk(9,3,1,7,1,ALU), nn, 0,0,0, 2'b00,1,0,0,0);
        add(1,0,0,2'b00, nn, nn, 2'b01,7,0, 2'b00,1,1,0,0);
        add(1,0,0,2'b00, nn, nn, 2'b10,0,7, 2'b00,1,1,0,0);
        add(1,0,0,2'b00, nn, nn, 2'b00,7,0, 2'b01,1,1,9,0);
        // load-use on c1 only, then ld_rd=0 ignored
        add(1,0,0,2'b11, mk(10,4,0,0,1,ALU), mk(11,8,2,0,1,ALU), 0,0,0, 2'b00,1,0,0,0);
        add(1,0,0,2'b00, nn, nn, 2'b01,2,0, 2'b01,1,2,10,0);
        add(1,0,0,2'b00, nn, nn, 2'b01,2,0, 2'b00,1,1,0,0);
        add(1,0,0,2'b00, nn, nn, 2'b01,0,0, 2'b01,1,1,11,0);
        // mem/mem and muldiv/muldiv issue singly; ALU then solo then next
        add(1,0,0,2'b11, mk(12,10,1,0,1,MEM), mk(13,11,2,0,1,MEM), 0,0,0, 2'b00,1,0,0,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b01,1,2,12,0);
        add(1,0,0,2'b11, mk(14,12,0,0,1,MD), mk(15,13,0,0,1,MD), 0,0,0, 2'b01,1,1,13,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b01,1,2,14,0);
        add(1,0,0,2'b11, mk(16,14,0,0,1,ALU), mk(17,0,0,0,0,SOLO), 0,0,0, 2'b01,1,1,15,0);
        add(1,0,0,2'b01, mk(18,15,0,0,1,ALU), nn, 0,0,0, 2'b01,1,2,16,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b01,1,2,17,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b01,1,1,18,0);
        // fill under stall, full refuses, then drain with wrap
        add(1,1,0,2'b11, mk(19,16,0,0,1,ALU), mk(20,17,3,0,1,ALU), 0,0,0, 2'b00,1,0,0,0);
        add(1,1,0,2'b11, mk(21,18,0,0,1,ALU), mk(22,19,0,0,1,ALU), 0,0,0, 2'b00,1,2,0,0);
        add(1,1,0,2'b11, mk(23,20,0,0,1,ALU), mk(24,21,0,0,1,ALU), 0,0,0, 2'b00,1,4,0,0);
        add(1,1,0,2'b11, mk(25,22,0,0,1,ALU), mk(26,23,0,0,1,ALU), 0,0,0, 2'b00,1,6,0,0);
        add(1,1,0,2'b11, mk(27,24,0,0,1,ALU), mk(28,25,0,0,1,ALU), 0,0,0, 2'b00,0,8,0,0);
        add(1,0,0,2'b00, nn, nn, 2'b01,3,0, 2'b01,0,8,19,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b11,0,7,20,21);
        add(1,0,0,2'b11, mk(27,24,0,0,1,ALU), mk(28,25,0,0,1,ALU), 0,0,0, 2'b11,1,5,22,23);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b11,1,5,24,25);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b11,1,3,26,27);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b01,1,1,28,0);
        // flush (with stall) drops state and the same-cycle enqueue
        add(1,0,0,2'b11, mk(29,1,0,0,1,ALU), mk(30,2,0,0,1,ALU), 0,0,0, 2'b00,1,0,0,0);
        add(1,1,0,2'b11, mk(31,3,0,0,1,ALU), mk(32,4,0,0,1,ALU), 0,0,0, 2'b00,1,2,0,0);
        add(1,1,1,2'b11, mk(33,5,0,0,1,ALU), mk(34,6,0,0,1,ALU), 0,0,0, 2'b00,1,4,0,0);
        add(1,0,0,2'b11, mk(35,7,0,0,1,ALU), mk(36,8,0,0,1,ALU), 0,0,0, 2'b00,1,0,0,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b11,1,2,35,36);
        // mid-operation reset
        add(1,0,0,2'b11, mk(37,9,0,0,1,ALU), mk(38,10,0,0,1,ALU), 0,0,0, 2'b00,1,0,0,0);
        add(0,1,0,2'b00, nn, nn, 0,0,0, 2'b00,1,2,0,0);
        add(1,0,0,2'b00, nn, nn, 0,0,0, 2'b00,1,0,0,0);

        foreach (vecs[i]) apply(vecs[i], i);

        // streaming: enqueue a pair every cycle, each pair issues the next cycle
        for (int k = 0; k < 7; k++) begin
            v = vecs[0];
            v.rstn = 1'b1; v.stall = 1'b0; v.flush = 1'b0; v.exv = 2'b00;
            v.iv = (k < 6) ? 2'b11 : 2'b00;
            v.i0 = mk(100 + 2*k, 1 + (k % 4), 0, 0, 1, ALU);
            v.i1 = mk(101 + 2*k, 5 + (k % 4), 0, 0, 1, ALU);
            v.ev = (k == 0) ? 2'b00 : 2'b11;
            v.er = 1'b1;
            v.ec = (k == 0) ? 4'd0 : 4'd2;
            v.et0 = 8'(98 + 2*k);
            v.et1 = 8'(99 + 2*k);
            apply(v, 100 + k);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
